// File: rtl/clk_divider_pkg.sv
// clk_divider_pkg: shared types for the reference-clock divider.
//   phase_e - encoding of the registered divided-clock level (div_q).
//             Each value is the output level it produces: PH_LOW drives 0,
//             PH_HIGH drives 1.
package clk_divider_pkg;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

endpackage : clk_divider_pkg

// File: rtl/clk_divider.sv
// clk_divider: integer clock divider with combinational bypass.
//   Divide mode (i_clk_en=1 and N>=2): o_div_clk comes from the registered
//   toggle flop div_q. Each period lasts N reference cycles. The low phase
//   is ceil(N/2) cycles and the high phase is floor(N/2) cycles.
//   Bypass (i_clk_en=0 or N<2): o_div_clk = i_ref_clk. The counter and div_q
//   are held at 0, so every entry into divide mode starts with a full low
//   phase.
// Ports:
//   i_ref_clk   - reference clock; all state updates on its rising edge
//   i_rst_n     - asynchronous active-low reset (clears counter and div_q)
//   i_clk_en    - divider enable; 0 selects bypass
//   i_div_ratio - unsigned division ratio N (DIV_RATIO_WIDTH bits)
//   o_div_clk   - divided clock, or i_ref_clk in bypass
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int unsigned DIV_RATIO_WIDTH = 4
) (
  input  logic                       i_ref_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clk_en,
  input  logic [DIV_RATIO_WIDTH-1:0] i_div_ratio,
  output logic                       o_div_clk
);

  localparam int unsigned W = DIV_RATIO_WIDTH;

  logic [W-1:0] cnt_q, cnt_d;
  phase_e       div_q, div_d;

  // Phase lengths use one extra bit so that N+1 cannot wrap at the largest N.
  logic [W:0]   ratio_ext;
  logic [W:0]   low_len;
  logic [W:0]   high_len;
  logic [W:0]   phase_len;
  logic         bypass;

  always_comb begin
    ratio_ext = {1'b0, i_div_ratio};
    low_len   = (ratio_ext + 1'b1) >> 1;
    high_len  = ratio_ext >> 1;
    bypass    = !i_clk_en || (ratio_ext < (W + 1)'(2));
    phase_len = (div_q == PH_HIGH) ? high_len : low_len;
  end

  // Terminal test is ">=" rather than "==". If N shrinks mid-phase, the
  // counter may already be past the new terminal count. In that case the
  // phase ends on the next edge instead of running the counter round.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    div_d = div_q;
    if (bypass) begin
      cnt_d = '0;
      div_d = PH_LOW;
    end else if ({1'b0, cnt_q} >= (phase_len - 1'b1)) begin
      cnt_d = '0;
      div_d = (div_q == PH_HIGH) ? PH_LOW : PH_HIGH;
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      div_q <= PH_LOW;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign o_div_clk = bypass ? i_ref_clk : (div_q == PH_HIGH);

endmodule : clk_divider

// File: tb/tb_clk_divider.sv
// tb_clk_divider: scoreboard bench for clk_divider.
//   The driver applies directed segments and queues the expected o_div_clk
//   level for every half reference cycle. The monitor samples 2 ns after each
//   reference-clock edge, pops one expectation and compares.
//   For divide segments, the table gives hand-computed low/high phase lengths.
//   The expected level k edges after mode entry is 1 when
//   (k mod (lo+hi)) >= lo, and 0 otherwise.
module tb_clk_divider;

  logic       ref_clk   = 1'b0;
  logic       rst_n     = 1'b0;
  logic       clk_en    = 1'b0;
  logic [3:0] div_ratio = 4'd0;
  logic       div_clk;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  always #5 ref_clk = ~ref_clk;

  clk_divider #(
    .DIV_RATIO_WIDTH(4)
  ) dut (
    .i_ref_clk  (ref_clk),
    .i_rst_n    (rst_n),
    .i_clk_en   (clk_en),
    .i_div_ratio(div_ratio),
    .o_div_clk  (div_clk)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one sample per half cycle, compared only when an expectation is queued.
  initial begin
    forever begin
      @(ref_clk);
      #2;
      if (exp_q.size() > 0) begin
        logic e;
        e = exp_q.pop_front();
        check("div_clk", div_clk, e);
      end
    end
  end

  // lo == 0 marks a bypass segment, where the output follows the clock level.
  // A negative k is a state before any edge of this segment; there, 'pre'
  // gives the level carried over from the previous segment.
  function automatic logic exp_val(input int k, input logic lvl, input int lo,
                                   input int hi, input logic pre);
    if (lo == 0) return lvl;
    if (k < 0) return pre;
    return ((k % (lo + hi)) >= lo);
  endfunction

  // Call at a falling edge. The segment returns at the falling edge that
  // ends its last cycle.
  task automatic seg(input logic en, input logic [3:0] n, input int cyc,
                     input int lo, input int hi, input int k0, input logic pre);
    clk_en    = en;
    div_ratio = n;
    for (int k = 0; k < cyc; k++) begin
      exp_q.push_back(exp_val(k + k0, 1'b0, lo, hi, pre));
      @(posedge ref_clk);
      exp_q.push_back(exp_val(k + 1 + k0, 1'b1, lo, hi, pre));
      @(negedge ref_clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held in bypass: output still follows the reference clock.
    @(negedge ref_clk);
    seg(1'b0, 4'd0, 2, 0, 0, 0, 1'b0);
    rst_n = 1'b1;
    // Bypass with enable low: identical to the reference clock.
    seg(1'b0, 4'd0, 5, 0, 0, 0, 1'b0);
    // N=2: 1 low / 1 high.
    seg(1'b1, 4'd2, 10, 1, 1, 0, 1'b0);
    seg(1'b0, 4'd2, 2, 0, 0, 0, 1'b0);
    // N=4: 2/2. The first rise comes two reference cycles after entry.
    seg(1'b1, 4'd4, 40, 2, 2, 0, 1'b0);
    // Enable high with N=1 is bypass.
    seg(1'b1, 4'd1, 3, 0, 0, 0, 1'b0);
    // N=3: 2 low / 1 high.
    seg(1'b1, 4'd3, 30, 2, 1, 0, 1'b0);
    // Enable high with N=0 is bypass.
    seg(1'b1, 4'd0, 2, 0, 0, 0, 1'b0);
    // N=5: 3 low / 2 high.
    seg(1'b1, 4'd5, 50, 3, 2, 0, 1'b0);
    seg(1'b0, 4'd5, 2, 0, 0, 0, 1'b0);
    // N=15 (largest ratio): 8 low / 7 high.
    seg(1'b1, 4'd15, 32, 8, 7, 0, 1'b0);
    seg(1'b0, 4'd0, 2, 0, 0, 0, 1'b0);

    // Ratio change from 4 to 3 mid-phase. After three N=4 edges the output is
    // high with the counter at 1. The new high length is 1, so the first
    // N=3 edge ends the phase. After that the 2/1 pattern runs from a fresh
    // low phase, which is the same as k0 = -1.
    seg(1'b1, 4'd4, 3, 2, 2, 0, 1'b0);
    seg(1'b1, 4'd3, 9, 2, 1, -1, 1'b1);
    seg(1'b0, 4'd0, 2, 0, 0, 0, 1'b0);

    // Asynchronous reset in the middle of a high phase with N=4.
    seg(1'b1, 4'd4, 3, 2, 2, 0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", div_clk, 1'b0);
    @(negedge ref_clk);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(1'b0);
      @(posedge ref_clk);
      exp_q.push_back(1'b0);
      @(negedge ref_clk);
    end
    rst_n = 1'b1;
    seg(1'b1, 4'd4, 8, 2, 2, 0, 1'b0);

    @(negedge ref_clk);
    @(negedge ref_clk);
    check("queue_drained", (exp_q.size() == 0), 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_clk_divider
